// File: rtl/multicycle_sequencer_if.sv
// Purpose: groups the sequencer's control inputs, memory handshakes, strobes and status.
// Latency: none, wiring only.
// Backpressure: req/ack pairs; a request holds until its ack, and acks without a request are ignored.
interface multicycle_sequencer_if #(
  parameter int PERF_CNT_W = 32
);
  logic                  run;
  logic [31:0]           instr;
  logic                  RegWr;
  logic                  MemtoReg;
  logic                  MemWr;
  logic                  imem_req;
  logic                  imem_ack;
  logic                  ir_we;
  logic                  dmem_req;
  logic                  dmem_we;
  logic                  dmem_ack;
  logic                  rf_we;
  logic                  pc_we;
  logic                  halt;
  logic                  fault;
  logic [2:0]            state;
  logic [PERF_CNT_W-1:0] instret;

  // Sequencer side
  modport master (
    input  run, instr, RegWr, MemtoReg, MemWr, imem_ack, dmem_ack,
    output imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, halt, fault, state, instret
  );

  // Datapath / memory side
  modport slave (
    output run, instr, RegWr, MemtoReg, MemWr, imem_ack, dmem_ack,
    input  imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, halt, fault, state, instret
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Purpose: multi-cycle RV32I control FSM (fetch/decode/exec/mem/wb) with a memory-wait watchdog and instret counter.
// Latency: with zero-wait memory, ALU and store take 4 cycles and load takes 5; each memory wait cycle adds 1.
// Backpressure: imem_req and dmem_req stay high until their ack; MEM_WAIT_MAX unacked cycles send the FSM to FAULT.
module multicycle_sequencer #(
  parameter int MEM_WAIT_MAX = 16,
  parameter int PERF_CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  localparam int                WAIT_W    = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);
  localparam logic [31:0]       EBREAK    = 32'h0010_0073;

  state_t                state_q, state_d;
  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [PERF_CNT_W-1:0] instret_q;
  logic                  retire;

  logic imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, halt, fault;

  // State, watchdog counter and retired-instruction counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (retire) begin
        instret_q <= instret_q + PERF_CNT_W'(1);
      end
    end
  end

  // Next-state, watchdog and strobe decode; outputs depend only on the current state and inputs
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    retire     = 1'b0;
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    rf_we      = 1'b0;
    pc_we      = 1'b0;
    halt       = 1'b0;
    fault      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          state_d    = S_FETCH;
          wait_cnt_d = '0;
        end
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ack) begin
          // IR captures the fetched word in the same cycle as the ack
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      S_DECODE: begin
        state_d = (bus.instr == EBREAK) ? S_HALT : S_EXEC;
      end

      S_EXEC: begin
        if (bus.MemtoReg || bus.MemWr) begin
          state_d    = S_MEM;
          wait_cnt_d = '0;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = bus.MemWr;
        if (bus.dmem_ack) begin
          if (bus.MemWr) begin
            // A store has nothing to write back, so it retires on its ack
            pc_we      = 1'b1;
            retire     = 1'b1;
            state_d    = bus.run ? S_FETCH : S_IDLE;
            wait_cnt_d = '0;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      S_WB: begin
        rf_we      = bus.RegWr;
        pc_we      = 1'b1;
        retire     = 1'b1;
        state_d    = bus.run ? S_FETCH : S_IDLE;
        wait_cnt_d = '0;
      end

      S_HALT: begin
        halt = 1'b1;
        if (!bus.run) begin
          state_d = S_IDLE;
        end
      end

      S_FAULT: begin
        // Terminal until reset: a stuck memory must not be retried silently
        fault = 1'b1;
      end

      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

  assign bus.imem_req = imem_req;
  assign bus.ir_we    = ir_we;
  assign bus.dmem_req = dmem_req;
  assign bus.dmem_we  = dmem_we;
  assign bus.rf_we    = rf_we;
  assign bus.pc_we    = pc_we;
  assign bus.halt     = halt;
  assign bus.fault    = fault;
  assign bus.state    = state_q;
  assign bus.instret  = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Purpose: scoreboard bench for multicycle_sequencer; per-cycle expected control vectors are queued as stimulus is driven.
// Latency: expectations are checked on the falling edge of the cycle they were pushed in.
// Backpressure: memory ack timing is scripted per test, including late acks and a stuck fetch.
module tb_multicycle_sequencer;

  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
                         MEM = 3'd4, WB = 3'd5, HALT = 3'd6, FAULT = 3'd7;

  localparam logic [7:0] F_IREQ = 8'h80, F_IRWE = 8'h40, F_DREQ = 8'h20, F_DWE = 8'h10,
                         F_RFWE = 8'h08, F_PCWE = 8'h04, F_HALT = 8'h02, F_FLT  = 8'h01;

  localparam logic [31:0] I_ADDI = 32'h0050_0093, I_LW = 32'h0000_a103,
                          I_SW = 32'h0020_a023, I_EBREAK = 32'h0010_0073;

  typedef struct packed {
    logic [10:0] ctl;
    logic [3:0]  ir;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  exp_t       exp_q[$];
  logic [3:0] exp_instret;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  multicycle_sequencer_if #(.PERF_CNT_W(4)) sif ();

  multicycle_sequencer #(
    .MEM_WAIT_MAX(4),
    .PERF_CNT_W  (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (sif)
  );

  function automatic logic [10:0] ctl_now();
    return {sif.state, sif.imem_req, sif.ir_we, sif.dmem_req, sif.dmem_we,
            sif.rf_we, sif.pc_we, sif.halt, sif.fault};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: compare each queued expectation mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("ctl{state,ireq,irwe,dreq,dwe,rfwe,pcwe,halt,fault}", 32'(ctl_now()), 32'(e.ctl));
      check("instret", 32'(sif.instret), 32'(e.ir));
    end
  end

  task automatic dec(input logic [31:0] ins, input logic rw, input logic m2r, input logic mw);
    sif.instr    = ins;
    sif.RegWr    = rw;
    sif.MemtoReg = m2r;
    sif.MemWr    = mw;
  endtask

  // One clock cycle: drive inputs, queue the expected outputs, advance to the next posedge+1
  task automatic cyc(input logic r, input logic ia, input logic da,
                     input logic [2:0] st, input logic [7:0] fl);
    exp_t e;
    sif.run      = r;
    sif.imem_ack = ia;
    sif.dmem_ack = da;
    e.ctl = {st, fl};
    e.ir  = exp_instret;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int delay);
    for (int i = 0; i < delay; i++) cyc(1'b1, 1'b0, 1'b0, FETCH, F_IREQ);
    cyc(1'b1, 1'b1, 1'b0, FETCH, F_IREQ | F_IRWE);
  endtask

  initial begin
    rst_n        = 1'b0;
    sif.run      = 1'b0;
    sif.imem_ack = 1'b0;
    sif.dmem_ack = 1'b0;
    dec(32'h0, 1'b0, 1'b0, 1'b0);
    exp_instret  = 4'd0;

    #2;
    check("reset_outputs", 32'(ctl_now()), 32'd0);
    check("reset_instret", 32'(sif.instret), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ALU op; run drops mid-instruction, instruction still completes
    dec(I_ADDI, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, IDLE, 8'h00);
    fetch(0);
    cyc(1'b0, 1'b0, 1'b0, DECODE, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, EXEC, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, WB, F_RFWE | F_PCWE);
    exp_instret++;
    cyc(1'b0, 1'b0, 1'b0, IDLE, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, IDLE, 8'h00);

    // Load with ack 3 cycles late (lands on the last watchdog cycle); stray acks while req=0
    dec(I_LW, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, IDLE, 8'h00);
    fetch(0);
    cyc(1'b1, 1'b1, 1'b1, DECODE, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, EXEC, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, MEM, F_DREQ);
    cyc(1'b1, 1'b0, 1'b1, MEM, F_DREQ);
    cyc(1'b1, 1'b0, 1'b0, WB, F_RFWE | F_PCWE);
    exp_instret++;

    // Store with a 2-cycle late fetch; retires on the dmem ack and goes straight to FETCH
    dec(I_SW, 1'b0, 1'b0, 1'b1);
    fetch(2);
    cyc(1'b1, 1'b0, 1'b0, DECODE, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, EXEC, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, MEM, F_DREQ | F_DWE | F_PCWE);
    exp_instret++;

    // ebreak: halt, no strobes, acks ignored, run=0 returns to IDLE
    dec(I_EBREAK, 1'b0, 1'b0, 1'b0);
    fetch(0);
    cyc(1'b1, 1'b0, 1'b0, DECODE, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, HALT, F_HALT);
    cyc(1'b1, 1'b1, 1'b1, HALT, F_HALT);
    cyc(1'b0, 1'b0, 1'b0, HALT, F_HALT);
    cyc(1'b0, 1'b0, 1'b0, IDLE, 8'h00);

    // Asynchronous reset while a load is waiting in MEM
    dec(I_LW, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, IDLE, 8'h00);
    fetch(0);
    cyc(1'b1, 1'b0, 1'b0, DECODE, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, EXEC, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, MEM, F_DREQ);
    #1;
    check("mem_req_before_reset", 32'(sif.dmem_req), 32'd1);
    check("instret_before_reset", 32'(sif.instret), 32'd3);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'(ctl_now()), 32'd0);
    check("async_reset_instret", 32'(sif.instret), 32'd0);
    exp_instret = 4'd0;
    @(posedge clk);
    #1;
    check("reset_held_outputs", 32'(ctl_now()), 32'd0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, IDLE, 8'h00);

    // 16 back-to-back ALU ops wrap the 4-bit instret counter to 0
    for (int k = 0; k < 16; k++) begin
      logic        rw;
      logic [31:0] ins;
      rw  = 1'($urandom_range(0, 1));
      ins = ($urandom & 32'hFFFF_FF00) | 32'h13;
      dec(ins, rw, 1'b0, 1'b0);
      if (k == 0) cyc(1'b1, 1'b0, 1'b0, IDLE, 8'h00);
      fetch(int'($urandom_range(0, 2)));
      cyc(1'b1, 1'b0, 1'b0, DECODE, 8'h00);
      cyc(1'b1, 1'b0, 1'b0, EXEC, 8'h00);
      cyc((k == 15) ? 1'b0 : 1'b1, 1'b0, 1'b0, WB, rw ? (F_RFWE | F_PCWE) : F_PCWE);
      exp_instret++;
    end
    cyc(1'b0, 1'b0, 1'b0, IDLE, 8'h00);
    check("instret_wrapped", 32'(sif.instret), 32'd0);

    // Stuck fetch: 4 unacked req cycles then FAULT, which ignores acks and run
    dec(I_ADDI, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, IDLE, 8'h00);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, FETCH, F_IREQ);
    cyc(1'b1, 1'b0, 1'b0, FAULT, F_FLT);
    cyc(1'b0, 1'b1, 1'b1, FAULT, F_FLT);
    cyc(1'b1, 1'b1, 1'b0, FAULT, F_FLT);
    cyc(1'b0, 1'b0, 1'b1, FAULT, F_FLT);
    rst_n = 1'b0;
    #1;
    check("fault_reset_outputs", 32'(ctl_now()), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, IDLE, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, IDLE, 8'h00);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
